// File: rtl/pll_lock_monitor_if.sv
// Monitor-side bundle: reference input and controls in, lock status and measurement out.
// Carries no flow control; every output is a registered level or single-cycle pulse.
// master drives the controls and observes the status; slave is the monitor itself.
interface pll_lock_monitor_if #(
    parameter int CNT_W = 16
);
    logic             ref_in;
    logic             enable;
    logic             err_clr;
    logic             locked;
    logic             ref_lost;
    logic [CNT_W-1:0] meas;
    logic             meas_valid;
    logic [7:0]       err_cnt;

    modport master (
        output ref_in, enable, err_clr,
        input  locked, ref_lost, meas, meas_valid, err_cnt
    );

    modport slave (
        input  ref_in, enable, err_clr,
        output locked, ref_lost, meas, meas_valid, err_cnt
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// Purpose: frequency-checks the local clock against an async reference; derives LOCKED / REF_LOST.
// Latency: REF_IN edge reaches the logic 3 clk later; all outputs registered, MEAS_VALID 1 clk after close.
// Backpressure: none; MEAS_VALID is a one-shot pulse and is not held for a consumer.
module pll_lock_monitor #(
    parameter int REF_EDGES    = 16,
    parameter int RATIO        = 10,
    parameter int TOL          = 2,
    parameter int LOCK_WINDOWS = 4,
    parameter int TIMEOUT      = 64,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    pll_lock_monitor_if.slave mon
);
    localparam int EDGE_W = $clog2(REF_EDGES + 1);
    localparam int GAP_W  = $clog2(TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam int TARGET = REF_EDGES * RATIO;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   MEAS_LO = (CNT_W+1)'((TARGET > TOL) ? TARGET - TOL : 0);
    localparam logic [CNT_W:0]   MEAS_HI = (CNT_W+1)'(TARGET + TOL);

    typedef enum logic [1:0] {IDLE, ALIGN, MEASURE, LOST} state_t;

    state_t            state, state_nxt;
    logic              s1, s2, s3;
    logic              ref_edge;
    logic [CNT_W-1:0]  cnt;
    logic [EDGE_W-1:0] edges;
    logic [GAP_W-1:0]  gap;
    logic [GOOD_W-1:0] good_cnt;
    logic              locked_q, ref_lost_q, meas_valid_q;
    logic [CNT_W-1:0]  meas_q;
    logic [7:0]        err_q;

    logic              track_gap, timeout, open_win, close_win, win_sat, win_good;
    logic [CNT_W:0]    meas_sum;
    logic [CNT_W-1:0]  meas_new;
    logic [GOOD_W-1:0] good_inc;

    assign ref_edge = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!mon.enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ALIGN;
                ALIGN:   if (timeout) state_nxt = LOST;
                         else if (ref_edge) state_nxt = MEASURE;
                MEASURE: if (timeout) state_nxt = LOST;
                LOST:    if (ref_edge) state_nxt = MEASURE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Timeout and edge are exclusive by construction, so timeout outranks a window close.
    always_comb begin
        track_gap = (state == ALIGN) || (state == MEASURE);
        timeout   = mon.enable && track_gap && !ref_edge && (gap == GAP_W'(TIMEOUT - 1));
        open_win  = mon.enable && ref_edge && ((state == ALIGN) || (state == LOST));
        close_win = mon.enable && ref_edge && (state == MEASURE)
                    && (edges == EDGE_W'(REF_EDGES - 1));
        win_sat   = (cnt == CNT_MAX);
        meas_sum  = {1'b0, cnt} + (CNT_W+1)'(1);
        meas_new  = win_sat ? cnt : meas_sum[CNT_W-1:0];
        win_good  = !win_sat && (meas_sum >= MEAS_LO) && (meas_sum <= MEAS_HI);
        good_inc  = (good_cnt == GOOD_W'(LOCK_WINDOWS)) ? good_cnt : good_cnt + GOOD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, s3}  <= 3'b000;
            cnt           <= '0;
            edges         <= '0;
            gap           <= '0;
            good_cnt      <= '0;
            locked_q      <= 1'b0;
            ref_lost_q    <= 1'b0;
            meas_q        <= '0;
            meas_valid_q  <= 1'b0;
            err_q         <= '0;
        end else begin
            s1           <= mon.ref_in;
            s2           <= s1;
            s3           <= s2;
            meas_valid_q <= 1'b0;
            if (!mon.enable) begin
                cnt        <= '0;
                edges      <= '0;
                gap        <= '0;
                good_cnt   <= '0;
                locked_q   <= 1'b0;
                ref_lost_q <= 1'b0;
            end else begin
                if (timeout || ref_edge || !track_gap) gap <= '0;
                else                                   gap <= gap + GAP_W'(1);

                if (timeout) begin
                    ref_lost_q <= 1'b1;
                    locked_q   <= 1'b0;
                    good_cnt   <= '0;
                    cnt        <= '0;
                    edges      <= '0;
                end else if (open_win) begin
                    ref_lost_q <= 1'b0;
                    cnt        <= '0;
                    edges      <= '0;
                end else if (close_win) begin
                    // The closing edge doubles as the opening edge of the next window.
                    cnt          <= '0;
                    edges        <= '0;
                    meas_q       <= meas_new;
                    meas_valid_q <= 1'b1;
                    if (win_good) begin
                        good_cnt <= good_inc;
                        locked_q <= (good_inc == GOOD_W'(LOCK_WINDOWS));
                    end else begin
                        good_cnt <= '0;
                        locked_q <= 1'b0;
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                    end
                end else if (state == MEASURE) begin
                    if (!win_sat) cnt <= cnt + CNT_W'(1);
                    if (ref_edge) edges <= edges + EDGE_W'(1);
                end
            end
            if (mon.err_clr) err_q <= '0;
        end
    end

    assign mon.locked     = locked_q;
    assign mon.ref_lost   = ref_lost_q;
    assign mon.meas       = meas_q;
    assign mon.meas_valid = meas_valid_q;
    assign mon.err_cnt    = err_q;
endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: REF_IN driven as a list of periods; a window-level model predicts each MEAS_VALID.
module tb_pll_lock_monitor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pll_lock_monitor_if bus();
    pll_lock_monitor dut (.clk(clk), .rst(rst), .mon(bus));

    typedef struct { int meas; int locked; int err; } win_t;
    win_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Window-level reference: sums of REF_IN periods between every 16th rising edge.
    bit m_open;
    int m_sum, m_n, m_prev, m_run, m_err, m_locked;
    int last_meas;
    bit was_lost;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic clr);
        win_t e;
        bus.ref_in  = r;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
        if (bus.meas_valid === 1'b1) begin
            chk("meas_valid_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("meas", bus.meas, e.meas);
                chk("locked", bus.locked, e.locked);
                chk("err_cnt", bus.err_cnt, e.err);
                chk("ref_lost_at_meas", bus.ref_lost, 0);
                last_meas = e.meas;
            end
        end
    endtask

    task automatic model_edge(input bit clr);
        bit   closed;
        int   d;
        win_t e;
        closed = 1'b0;
        if (!m_open) begin
            m_open = 1'b1;
            m_sum  = 0;
            m_n    = 0;
        end else begin
            m_sum += m_prev;
            m_n++;
            if (m_n == 16) begin
                closed = 1'b1;
                d = m_sum - 160;
                if (d < 0) d = -d;
                if (d <= 2) begin
                    m_run++;
                    m_locked = (m_run >= 4) ? 1 : 0;
                end else begin
                    m_run    = 0;
                    m_locked = 0;
                    if (m_err < 255) m_err++;
                end
            end
        end
        if (clr) m_err = 0;
        if (closed) begin
            e.meas = m_sum; e.locked = m_locked; e.err = m_err;
            exp_q.push_back(e);
            m_sum = 0;
            m_n   = 0;
        end
    endtask

    task automatic model_abort();
        m_open = 1'b0; m_run = 0; m_locked = 0;
    endtask

    // One REF_IN period of p clocks starting with a rising edge; p >= 100 starves the monitor.
    task automatic drive_period(input int p, input bit clr);
        bit lost_now;
        lost_now = (p >= 100);
        model_edge(clr);
        m_prev = p;
        if (lost_now) model_abort();
        for (int i = 0; i < p; i++) begin
            step(i < p / 2, clr && (i == 2));
            if (was_lost && i == 2) begin
                chk("ref_lost_cleared", bus.ref_lost, 0);
                was_lost = 1'b0;
            end
        end
        if (lost_now) begin
            chk("ref_lost_set", bus.ref_lost, 1);
            chk("locked_after_loss", bus.locked, 0);
            was_lost = 1'b1;
        end
    endtask

    task automatic seg(input int p, input int n);
        for (int i = 0; i < n; i++) drive_period(p, 1'b0);
    endtask

    task automatic model_reset();
        model_abort();
        m_err = 0; m_sum = 0; m_n = 0; m_prev = 0;
        last_meas = 0; was_lost = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        model_reset();
        bus.ref_in = 1'b0; bus.enable = 1'b0; bus.err_clr = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_ref_lost", bus.ref_lost, 0);
        chk("rst_meas", bus.meas, 0);
        chk("rst_meas_valid", bus.meas_valid, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;
        bus.enable = 1'b1;

        // Nominal lock, then a slow window and relock.
        seg(10, 64);
        seg(11, 16);
        chk("lock1_locked", bus.locked, 1);
        chk("lock1_meas", bus.meas, 160);
        seg(10, 1);
        chk("slow_meas", bus.meas, 176);
        chk("slow_locked", bus.locked, 0);
        chk("slow_err", bus.err_cnt, 1);
        seg(10, 64);
        chk("relock_locked", bus.locked, 1);
        chk("relock_err", bus.err_cnt, 1);

        // Tolerance edges: +2 stays good, +3 is bad.
        seg(10, 14); seg(12, 1); seg(10, 1);
        chk("tol2_meas", bus.meas, 162);
        chk("tol2_locked", bus.locked, 1);
        chk("tol2_err", bus.err_cnt, 1);
        seg(10, 14); seg(13, 1); seg(10, 1);
        chk("tol3_meas", bus.meas, 163);
        chk("tol3_locked", bus.locked, 0);
        chk("tol3_err", bus.err_cnt, 2);

        // Clear coinciding with a bad window close.
        seg(10, 14); seg(13, 1); drive_period(10, 1'b1);
        chk("clr_bad_meas", bus.meas, 163);
        chk("clr_bad_err", bus.err_cnt, 0);

        // Reference loss while locked, then recovery.
        seg(10, 64);
        chk("preloss_locked", bus.locked, 1);
        drive_period(150, 1'b0);
        seg(10, 17);
        chk("recover_meas", bus.meas, 160);
        chk("recover_ref_lost", bus.ref_lost, 0);
        chk("recover_locked", bus.locked, 0);

        // Randomised jitter and sporadic clears.
        for (int i = 0; i < 320; i++)
            drive_period(($urandom_range(0, 3) == 0) ? int'($urandom_range(7, 13)) : 10,
                         $urandom_range(0, 63) == 0);

        // Disable mid-window.
        seg(10, 85);
        chk("predis_locked", bus.locked, 1);
        seg(10, 5);
        bus.enable = 1'b0;
        model_abort();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("dis_locked", bus.locked, 0);
        chk("dis_ref_lost", bus.ref_lost, 0);
        chk("dis_meas_hold", bus.meas, last_meas);
        chk("dis_err_hold", bus.err_cnt, m_err);
        bus.enable = 1'b1;

        // Long run of bad windows saturates the error counter.
        seg(6, 4801);
        chk("err_saturated", bus.err_cnt, 255);

        // Reset mid-window.
        seg(6, 5);
        rst = 1'b1;
        model_reset();
        step(1'b0, 1'b0);
        chk("mid_rst_locked", bus.locked, 0);
        chk("mid_rst_ref_lost", bus.ref_lost, 0);
        chk("mid_rst_meas", bus.meas, 0);
        chk("mid_rst_meas_valid", bus.meas_valid, 0);
        chk("mid_rst_err", bus.err_cnt, 0);
        rst = 1'b0;
        seg(10, 17);
        chk("post_rst_meas", bus.meas, 160);
        chk("post_rst_err", bus.err_cnt, 0);

        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        chk("no_pending_windows", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
